mem_stage_lsu: RTL and testbench

Memory-stage load/store unit for the 5-stage RISC-V pipeline. It consumes the EX/MEM register outputs and runs a request/acknowledge transaction on the data-memory bus for loads and stores. It stalls the upstream pipeline while the transaction is outstanding, and drives the MEM/WB register, which is fused into this block, with aligned and sign/zero-extended load data.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/lsu_load_align.sv | 28 ++
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package riscv_pkg;

  // Memory-stage transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Access size/sign encodings carried in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A halfword must sit on an even byte; a word must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    is_misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                    ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it. Unknown funct3 codes return the whole word.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  // Addressed lanes moved down to bit 0; lanes above byte 3 shift in as zero.
  logic [15:0] lane;
  assign lane = 16'(rdata_i >> {offset_i, 3'b000});

  // Extension by access type.
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data_o = {24'h0, lane[7:0]};
      F3_HU:   data_o = {16'h0, lane[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit with the MEM/WB register folded in.
// Bus handshake: DReq rises in REQ and holds DAddr/DWe/DWData/DBe stable until
// the cycle DAck is seen high; DRData is taken in that same cycle, and DReq is
// low in the following cycle. DAck outside REQ has no effect.
// Build option: MISALIGN_TRAP_EN turns misaligned half/word accesses into a
// one-cycle MisalignM flag with no bus request and a MEM/WB bubble.
module mem_stage_lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [31:0] DWData,
  output logic [3:0]  DBe,
  input  logic        DAck,
  input  logic [31:0] DRData,
  output logic        StallM,
  output logic        MisalignM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output lsu_state_t  dbg_state_o
);

  lsu_state_t  state_q, state_d;
  logic        mem_op, misalign_c, issue;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] addr_q, wdata_q, rdata_q, load_ext;
  logic [3:0]  be_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] alu_w_q, rdata_w_q, pc4_w_q;
  logic [4:0]  rd_w_q;
  logic        rw_w_q;

  assign mem_op = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = mem_op & is_misaligned(Funct3M, ALUResultM[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  assign issue = (state_q == IDLE) && mem_op && !misalign_c;

  // Next-state: IDLE -> REQ on a memory op, REQ -> DONE on DAck, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = REQ;
      REQ:     if (DAck)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Store lane steering: replicate the datum and shift the enables by offset.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteDataM;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          be_c    = 4'b0001 << ALUResultM[1:0];
          wdata_c = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << ALUResultM[1:0];
          wdata_c = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Bus request latches, loaded once when the access is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
    end else if (issue) begin
      addr_q  <= {ALUResultM[31:2], 2'b00};
      wdata_q <= wdata_c;
      be_q    <= be_c;
      we_q    <= MemWriteM;
      off_q   <= ALUResultM[1:0];
      f3_q    <= Funct3M;
    end
  end

  lsu_load_align u_load_align (
    .rdata_i  (DRData),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (load_ext)
  );

  // Capture extended load data in the acknowledge cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          rdata_q <= '0;
    else if ((state_q == REQ) && DAck)  rdata_q <= we_q ? 32'h0 : load_ext;
  end

  // MEM/WB register: pass-through for ALU ops, bubble while a memory op runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_w_q   <= '0;
      rdata_w_q <= '0;
      pc4_w_q   <= '0;
      rd_w_q    <= '0;
      rw_w_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            alu_w_q   <= '0;
            rdata_w_q <= '0;
            pc4_w_q   <= '0;
            rd_w_q    <= '0;
            rw_w_q    <= 1'b0;
          end else begin
            alu_w_q   <= ALUResultM;
            rdata_w_q <= '0;
            pc4_w_q   <= PCPlus4M;
            rd_w_q    <= RdM;
            rw_w_q    <= RegWriteM;
          end
        end
        DONE: begin
          alu_w_q   <= ALUResultM;
          rdata_w_q <= rdata_q;
          pc4_w_q   <= PCPlus4M;
          rd_w_q    <= RdM;
          rw_w_q    <= RegWriteM;
        end
        default: ;
      endcase
    end
  end

  // Stall and trap flags are gated by reset so they fall immediately with it.
  assign StallM    = !reset && (issue || (state_q == REQ));
  assign MisalignM = !reset && (state_q == IDLE) && misalign_c;

  assign DReq        = (state_q == REQ);
  assign DWe         = we_q;
  assign DAddr       = addr_q;
  assign DWData      = wdata_q;
  assign DBe         = be_q;
  assign ALUResultW  = alu_w_q;
  assign ReadDataW   = rdata_w_q;
  assign PCPlus4W    = pc4_w_q;
  assign RdW         = rd_w_q;
  assign RegWriteW   = rw_w_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu.
module tb_mem_stage_lsu;
  import riscv_pkg::*;

  logic        clk, reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic        DReq, DWe, DAck, StallM, MisalignM, RegWriteW;
  logic [31:0] DAddr, DWData, DRData, ALUResultW, ReadDataW, PCPlus4W;
  logic [3:0]  DBe;
  logic [4:0]  RdW;
  lsu_state_t  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by the transaction driver.
  int          obs_cycles, obs_stall, obs_dreq, obs_mis, obs_rw_during, obs_unstable, obs_first_dreq;
  logic        obs_timeout;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe),
    .DAck(DAck), .DRData(DRData), .StallM(StallM), .MisalignM(MisalignM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .dbg_state_o(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_nop();
    ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
    RegWriteM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = '0;
  endtask

  // Runs one M-stage op (entered at posedge+1) until the cycle StallM is low,
  // acking after `waits` REQ cycles. Returns at posedge+1 after the last edge.
  task automatic do_mem(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd_idx, input logic rw,
                        input int waits, input logic [31:0] rdata);
    int   req_n;
    logic done;
    ALUResultM = addr; WriteDataM = wdata; PCPlus4M = addr + 32'd4; RdM = rd_idx;
    RegWriteM = rw; MemReadM = rd; MemWriteM = wr; Funct3M = f3;
    obs_cycles = 0; obs_stall = 0; obs_dreq = 0; obs_mis = 0; obs_rw_during = 0;
    obs_unstable = 0; obs_first_dreq = 0; obs_timeout = 1'b0;
    req_n = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      #1;
      obs_cycles = c;
      if (StallM) obs_stall++;
      if (MisalignM) obs_mis++;
      if (c > 1 && RegWriteW) obs_rw_during++;
      if (DReq) begin
        req_n++;
        obs_dreq++;
        if (req_n == 1) begin
          obs_first_dreq = c;
          obs_addr = DAddr; obs_wdata = DWData; obs_be = DBe; obs_we = DWe;
        end else if (DAddr !== obs_addr || DWData !== obs_wdata || DBe !== obs_be || DWe !== obs_we) begin
          obs_unstable++;
        end
        DAck   = (req_n - 1 == waits);
        DRData = rdata;
      end
      if (!StallM) done = 1'b1;
      @(posedge clk); #1;
      DAck = 1'b0;
    end
    if (!done) obs_timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; DAck = 1'b0; DRData = '0; set_nop();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({DReq, StallM, MisalignM, RegWriteW, DWe} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 00000", {DReq, StallM, MisalignM, RegWriteW, DWe});
    end
    n_tests++;
    if ({ALUResultW, ReadDataW, PCPlus4W, RdW, DAddr, DBe} !== '0) begin
      n_fail++; $display("FAIL reset_values: W/bus outputs not zero (ALUResultW %h ReadDataW %h DAddr %h)", ALUResultW, ReadDataW, DAddr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_alu();
    ALUResultM = 32'h0000_1234; RdM = 5'd5; RegWriteM = 1'b1; PCPlus4M = 32'h0000_0108;
    #1;
    n_tests++;
    if (StallM !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b exp 0", StallM); end
    @(posedge clk); #1;
    n_tests++;
    if (ALUResultW !== 32'h1234 || RdW !== 5'd5 || RegWriteW !== 1'b1 || ReadDataW !== 32'h0 || PCPlus4W !== 32'h108) begin
      n_fail++; $display("FAIL alu_w: got alu %h rd %0d rw %b rdata %h pc4 %h exp 1234 5 1 0 108", ALUResultW, RdW, RegWriteW, ReadDataW, PCPlus4W);
    end
    ALUResultM = 32'hDEAD_BEEF; RdM = 5'd31; RegWriteM = 1'b1; PCPlus4M = 32'h0000_0200;
    @(posedge clk); #1;
    n_tests++;
    if (ALUResultW !== 32'hDEAD_BEEF || RdW !== 5'd31 || StallM !== 1'b0) begin
      n_fail++; $display("FAIL alu_w2: got alu %h rd %0d stall %b exp deadbeef 31 0", ALUResultW, RdW, StallM);
    end
    set_nop();
  endtask

  task automatic test_store_byte();
    do_mem(1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0, 0, 32'h0);
    n_tests++;
    if (obs_timeout || obs_cycles != 3 || obs_stall != 2 || obs_dreq != 1) begin
      n_fail++; $display("FAIL sb_timing: got cycles %0d stall %0d dreq %0d exp 3 2 1", obs_cycles, obs_stall, obs_dreq);
    end
    n_tests++;
    if (obs_addr !== 32'h1000 || obs_be !== 4'b1000 || obs_wdata !== 32'hABAB_ABAB || obs_we !== 1'b1) begin
      n_fail++; $display("FAIL sb_bus: got addr %h be %b data %h we %b exp 00001000 1000 abababab 1", obs_addr, obs_be, obs_wdata, obs_we);
    end
    n_tests++;
    if (DReq !== 1'b0 || RegWriteW !== 1'b0) begin
      n_fail++; $display("FAIL sb_after: got dreq %b rw %b exp 0 0", DReq, RegWriteW);
    end
  endtask

  task automatic test_store_half();
    do_mem(1'b0, 1'b1, F3_H, 32'h0000_4002, 32'h1234_BEEF, 5'd0, 1'b0, 1, 32'h0);
    n_tests++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_addr !== 32'h4000 || obs_unstable != 0) begin
      n_fail++; $display("FAIL sh_bus: got be %b data %h addr %h unstable %0d exp 1100 beefbeef 00004000 0", obs_be, obs_wdata, obs_addr, obs_unstable);
    end
    n_tests++;
    if (obs_stall != 3 || obs_dreq != 2) begin
      n_fail++; $display("FAIL sh_timing: got stall %0d dreq %0d exp 3 2", obs_stall, obs_dreq);
    end
  endtask

  task automatic test_load_byte_wait();
    do_mem(1'b1, 1'b0, F3_B, 32'h0000_2001, 32'h0, 5'd7, 1'b1, 3, 32'h0000_8000);
    n_tests++;
    if (obs_timeout || obs_stall != 5 || obs_dreq != 4 || obs_cycles != 6) begin
      n_fail++; $display("FAIL lb_timing: got stall %0d dreq %0d cycles %0d exp 5 4 6", obs_stall, obs_dreq, obs_cycles);
    end
    n_tests++;
    if (obs_rw_during != 0 || obs_unstable != 0) begin
      n_fail++; $display("FAIL lb_bubble: got rw_during %0d unstable %0d exp 0 0", obs_rw_during, obs_unstable);
    end
    n_tests++;
    if (obs_be !== 4'b1111 || obs_we !== 1'b0 || obs_addr !== 32'h2000) begin
      n_fail++; $display("FAIL lb_bus: got be %b we %b addr %h exp 1111 0 00002000", obs_be, obs_we, obs_addr);
    end
    n_tests++;
    if (ReadDataW !== 32'hFFFF_FF80 || RegWriteW !== 1'b1 || RdW !== 5'd7 || ALUResultW !== 32'h2001) begin
      n_fail++; $display("FAIL lb_w: got rdata %h rw %b rd %0d alu %h exp ffffff80 1 7 00002001", ReadDataW, RegWriteW, RdW, ALUResultW);
    end
  endtask

  task automatic test_load_half_signed();
    do_mem(1'b1, 1'b0, F3_H, 32'h0000_4000, 32'h0, 5'd9, 1'b1, 1, 32'h0000_9ABC);
    n_tests++;
    if (ReadDataW !== 32'hFFFF_9ABC || RdW !== 5'd9) begin
      n_fail++; $display("FAIL lh_w: got rdata %h rd %0d exp ffff9abc 9", ReadDataW, RdW);
    end
  endtask

  task automatic test_back_to_back();
    do_mem(1'b1, 1'b0, F3_HU, 32'h0000_2002, 32'h0, 5'd10, 1'b1, 0, 32'hBEEF_0000);
    n_tests++;
    if (ReadDataW !== 32'h0000_BEEF || RdW !== 5'd10) begin
      n_fail++; $display("FAIL lhu_w: got rdata %h rd %0d exp 0000beef 10", ReadDataW, RdW);
    end
    do_mem(1'b1, 1'b0, F3_W, 32'h0000_2004, 32'h0, 5'd11, 1'b1, 1, 32'h1234_5678);
    n_tests++;
    if (obs_first_dreq != 2 || obs_stall != 3) begin
      n_fail++; $display("FAIL b2b_timing: got first_dreq %0d stall %0d exp 2 3", obs_first_dreq, obs_stall);
    end
    n_tests++;
    if (ReadDataW !== 32'h1234_5678 || RdW !== 5'd11 || ALUResultW !== 32'h2004) begin
      n_fail++; $display("FAIL lw_w: got rdata %h rd %0d alu %h exp 12345678 11 00002004", ReadDataW, RdW, ALUResultW);
    end
    set_nop();
  endtask

  task automatic test_ack_in_idle();
    set_nop();
    DAck = 1'b1; DRData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    DAck = 1'b0;
    n_tests++;
    if (dbg_state !== IDLE || StallM !== 1'b0 || DReq !== 1'b0) begin
      n_fail++; $display("FAIL ack_idle: got state %0d stall %b dreq %b exp 0 0 0", dbg_state, StallM, DReq);
    end
  endtask

  task automatic test_misalign();
    do_mem(1'b1, 1'b0, F3_W, 32'h0000_3002, 32'h0, 5'd12, 1'b1, 0, 32'hCAFE_F00D);
`ifdef MISALIGN_TRAP_EN
    n_tests++;
    if (obs_mis != 1 || obs_dreq != 0 || obs_stall != 0 || obs_cycles != 1) begin
      n_fail++; $display("FAIL mis_trap: got mis %0d dreq %0d stall %0d cycles %0d exp 1 0 0 1", obs_mis, obs_dreq, obs_stall, obs_cycles);
    end
    n_tests++;
    if (RegWriteW !== 1'b0 || RdW !== 5'd0) begin
      n_fail++; $display("FAIL mis_bubble: got rw %b rd %0d exp 0 0", RegWriteW, RdW);
    end
`else
    n_tests++;
    if (obs_mis != 0 || obs_dreq != 1 || obs_stall != 2 || obs_cycles != 3) begin
      n_fail++; $display("FAIL mis_plain: got mis %0d dreq %0d stall %0d cycles %0d exp 0 1 2 3", obs_mis, obs_dreq, obs_stall, obs_cycles);
    end
    n_tests++;
    if (obs_addr !== 32'h3000 || obs_be !== 4'b1111 || ReadDataW !== 32'hCAFE_F00D || RegWriteW !== 1'b1) begin
      n_fail++; $display("FAIL mis_plain_data: got addr %h be %b rdata %h rw %b exp 00003000 1111 cafef00d 1", obs_addr, obs_be, ReadDataW, RegWriteW);
    end
`endif
    set_nop();
  endtask

  task automatic test_reset_mid_req();
    ALUResultM = 32'h0000_5000; MemReadM = 1'b1; Funct3M = F3_W; RdM = 5'd3; RegWriteM = 1'b1;
    PCPlus4M = 32'h0000_5004;
    @(posedge clk); #1;
    n_tests++;
    if (DReq !== 1'b1 || dbg_state !== REQ) begin
      n_fail++; $display("FAIL mid_req_enter: got dreq %b state %0d exp 1 %0d", DReq, dbg_state, REQ);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (DReq !== 1'b0 || StallM !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0 ||
        ALUResultW !== 32'h0 || ReadDataW !== 32'h0 || PCPlus4W !== 32'h0) begin
      n_fail++; $display("FAIL mid_req_reset: got dreq %b stall %b rw %b rd %0d alu %h exp all zero", DReq, StallM, RegWriteW, RdW, ALUResultW);
    end
    set_nop();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (dbg_state !== IDLE || DReq !== 1'b0) begin
      n_fail++; $display("FAIL mid_req_release: got state %0d dreq %b exp %0d 0", dbg_state, DReq, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_byte();
    test_store_half();
    test_load_byte_wait();
    test_load_half_signed();
    test_back_to_back();
    test_ack_in_idle();
    test_misalign();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
